max_pool_window_sched: RTL and testbench
========================================

// Module: max_pool_window_sched
// PURPOSE
//   Streaming scheduler for the 2x2/stride-2 max-pooling stage. Takes a raster-order
//   16-bit pixel stream of one IMG_W x IMG_H feature map and buffers one row in a
//   line buffer. Presents each complete 2x2 window to an external max_pooling_unit
//   (SIZE=4) and registers the returned maximum onto a valid/ready output stream.
//   Sits between the convolution layer output and the next layer input.
// PARAMETERS
//   IMG_W  8  feature-map width in pixels; even, >=2
//   IMG_H  8  feature-map height in rows; even, >=2
// PORTS
//   clk         in   1   clock; all logic on rising edge
//   rst_n       in   1   synchronous active-low reset
//   start       in   1   1-cycle pulse, begins a frame; honoured only in IDLE
//   in_data     in   16  signed input pixel
//   in_valid    in   1   in_data valid
//   in_ready    out  1   pixel accepted when in_valid && in_ready
//   win_data    out  64  window to pool unit {cur[c], cur[c-1], lbuf[c], lbuf[c-1]}
//   pool_max    in   16  signed combinational max returned by pool unit
//   out_data    out  16  signed pooled result
//   out_valid   out  1   out_data valid; held until out_ready
//   out_ready   in   1   downstream accepts when out_valid && out_ready
//   busy        out  1   high in every state except IDLE
//   frame_done  out  1   1-cycle pulse at end of frame
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): state IDLE; col, row, held-pixel regs cleared.
//     in_ready=0, out_valid=0, out_data=0, busy=0, frame_done=0. Line buffer contents
//     are not cleared. Reset mid-frame aborts the frame with no frame_done pulse.
//   - FSM: IDLE -start-> FILL -> PAIR -> (FILL | DRAIN) -> IDLE.
//   - IDLE: in_ready=0; in_valid ignored; start -> FILL, row=0, col=0.
//   - FILL (even row): in_ready=1. Each accepted pixel goes to lbuf[col] and col++.
//     Acceptance at col=IMG_W-1 -> col=0, state PAIR.
//   - PAIR (odd row), even col: in_ready=1; accepted pixel goes to held reg, col++.
//   - PAIR, odd col: in_ready = !out_valid || out_ready (slot free this cycle).
//     win_data = {in_data, held, lbuf[col], lbuf[col-1]}, else 64'h0.
//     On acceptance, out_data <= pool_max and out_valid <= 1 on the next edge.
//     Latency is 1 cycle. A simultaneous downstream handshake and new load is legal,
//     with no bubble.
//   - End of PAIR row (accept at col=IMG_W-1): col=0. If row==IMG_H-2 -> DRAIN,
//     else row+=2 -> FILL.
//   - DRAIN: in_ready=0. Once out_valid==0, or on a cycle where out_valid&&out_ready,
//     the next cycle has frame_done=1 and state IDLE.
//   - out_valid deasserts only after a handshake. out_data is stable while
//     out_valid && !out_ready.
//   - Comparison is signed two's complement, done in the pool unit. There is no
//     widening; out_data is 16 bits.
//   - One frame yields exactly (IMG_W/2)*(IMG_H/2) outputs. in_valid gaps insert
//     stalls only.
//   - start is ignored outside IDLE.
// CONFIGURATION
//   MAXPOOL_RELU_EN defined: out_data <= (pool_max[15] ? 16'sd0 : pool_max), giving
//     a fused ReLU.
//   MAXPOOL_RELU_EN undefined: out_data <= pool_max unchanged.
// TESTING  (IMG_W=4, IMG_H=4, bench models the pool unit as a signed 4-way max)
//   - start, pixels 0..15 raster, out_ready=1 -> outputs 5,7,13,15. frame_done
//     pulses 1 cycle after output 15, then busy=0.
//   - All pixels -3 except pixel 5 = -1 -> first output 16'hFFFF (-1), others -3.
//     With MAXPOOL_RELU_EN the outputs are all 0.
//   - out_ready=0 from the first output -> in_ready=0 at the next odd PAIR column
//     and out_data holds 5. Releasing out_ready yields 5,7,13,15 with no loss.
//   - rst_n=0 for 1 cycle after 6 pixels -> out_valid=0, busy=0, in_ready=0. A new
//     start with frame 0..15 gives 5,7,13,15.
//   - start pulsed mid-frame, and in_valid=1 while in IDLE -> no effect, no pixel
//     accepted.
//   - in_valid toggled 1/0 every cycle on frame 0..15 -> same outputs 5,7,13,15.

Source files
------------

// File: rtl/max_pool_window_sched.sv
// max_pool_window_sched
//   Streaming scheduler for a 2x2 / stride-2 max-pooling stage. Accepts a raster-order
//   stream of signed 16-bit pixels for one IMG_W x IMG_H feature map. Even rows go into
//   a one-row line buffer. On odd rows each completed 2x2 window is presented to an
//   external combinational pool unit, and the returned maximum is registered onto a
//   valid/ready output stream.
//
// Configuration macro: MAXPOOL_RELU_EN. When defined, a ReLU is fused into the output
//   register, so negative maxima become 0.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   start                1-cycle pulse that begins a frame; only honoured in idle
//   in_data/valid/ready  pixel input stream
//   win_data             {cur[c], cur[c-1], lbuf[c], lbuf[c-1]} to the pool unit
//   pool_max             combinational signed max returned by the pool unit
//   out_data/valid/ready pooled result stream
//   busy                 high whenever a frame is in progress
//   frame_done           1-cycle pulse after the last result has been handed off
module max_pool_window_sched #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [15:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic        [63:0] win_data,
  input  logic signed [15:0] pool_max,
  output logic signed [15:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 2);

  typedef enum logic [1:0] {StIdle, StFill, StPair, StDrain} state_e;

  state_e             state_q;
  logic [CW-1:0]      col_q;
  logic [RW-1:0]      row_q;
  logic signed [15:0] held_q;
  logic signed [15:0] out_data_q;
  logic               out_valid_q;
  logic               frame_done_q;
  logic signed [15:0] lbuf_q [IMG_W];

  logic [CW-1:0]      col_m1;
  logic               accept;
  logic               col_odd;
  logic signed [15:0] pool_res;

  assign col_m1  = col_q - CW'(1);
  assign col_odd = col_q[0];
  assign accept  = in_valid && in_ready;

  // Odd pair columns complete a window and need a free output slot; the slot also
  // counts as free when the current result is being taken this very cycle.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StFill:  in_ready = 1'b1;
      StPair:  in_ready = col_odd ? (!out_valid_q || out_ready) : 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    win_data = 64'h0;
    if (state_q == StPair && col_odd) begin
      win_data = {in_data, held_q, lbuf_q[col_q], lbuf_q[col_m1]};
    end
  end

  always_comb begin
`ifdef MAXPOOL_RELU_EN
    pool_res = pool_max[15] ? 16'sd0 : pool_max;
`else
    pool_res = pool_max;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      held_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      // A load below overrides this, giving back-to-back results without a bubble.
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFill;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        StFill: begin
          if (accept) begin
            if (col_q == ColLast) begin
              col_q   <= '0;
              state_q <= StPair;
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        StPair: begin
          if (accept) begin
            if (!col_odd) begin
              held_q <= in_data;
            end else begin
              out_data_q  <= pool_res;
              out_valid_q <= 1'b1;
            end
            if (col_q == ColLast) begin
              col_q <= '0;
              if (row_q == RowLast) begin
                state_q <= StDrain;
              end else begin
                row_q   <= row_q + RW'(2);
                state_q <= StFill;
              end
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        StDrain: begin
          if (!out_valid_q || out_ready) begin
            state_q      <= StIdle;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Line buffer is plain storage: every entry is rewritten on a fill row before it is read.
  always_ff @(posedge clk) begin
    if (state_q == StFill && accept) begin
      lbuf_q[col_q] <= in_data;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool_window_sched.sv
// Bench for max_pool_window_sched at IMG_W=4, IMG_H=4. The pool unit is modelled as a
// signed 4-way max. Expected results come from window maxima computed directly on the
// frame array. Handshake expectations come from the stream rules: which pixel index
// completes a window, and whether the single output slot is occupied.
module tb_max_pool_window_sched;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int N    = W * H;
  localparam int NOUT = (W / 2) * (H / 2);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic        [63:0] win_data;
  logic signed [15:0] pool_max;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               frame_done;

  int n_asserts = 0;
  int n_fail    = 0;

  logic signed [15:0] px    [N];
  logic signed [15:0] exp_q [NOUT];

  always #5 clk = ~clk;

  max_pool_window_sched #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .win_data   (win_data),
    .pool_max   (pool_max),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  function automatic logic signed [15:0] max4(input logic signed [15:0] a, b, c, d);
    logic signed [15:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic signed [15:0] post(input logic signed [15:0] v);
`ifdef MAXPOOL_RELU_EN
    return (v < 0) ? 16'sd0 : v;
`else
    return v;
`endif
  endfunction

  // Pool unit model.
  always_comb pool_max = max4(win_data[63:48], win_data[47:32], win_data[31:16], win_data[15:0]);

  function automatic bit completes(input int idx);
    return ((idx / W) % 2 == 1) && ((idx % W) % 2 == 1);
  endfunction

  task automatic build_exp();
    for (int r = 0; r < H / 2; r++)
      for (int c = 0; c < W / 2; c++)
        exp_q[r * (W / 2) + c] = post(max4(px[(2 * r) * W + 2 * c], px[(2 * r) * W + 2 * c + 1],
                                           px[(2 * r + 1) * W + 2 * c],
                                           px[(2 * r + 1) * W + 2 * c + 1]));
  endtask

  task automatic chk(input logic [63:0] obs, input logic [63:0] expv, input string tag);
    n_asserts++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) px[i] = 16'(i);
  endtask

  // vmode: 0 always valid, 1 toggle, 2 random. rmode: 0 always ready, 1 stall first
  // result for 8 cycles, 2 random. start_at >= 0 pulses start mid-frame.
  task automatic run_frame(input int vmode, input int rmode, input int start_at, input string tag);
    int   pix, oidx, stall;
    logic expv, fin, done, exp_rdy, acc, hs;
    build_exp();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    pix = 0; oidx = 0; stall = 8; expv = 1'b0; fin = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      start = (cyc == start_at);
      case (vmode)
        0:       in_valid = (pix < N);
        1:       in_valid = (pix < N) && (cyc % 2 == 0);
        default: in_valid = (pix < N) && ($urandom_range(0, 2) != 0);
      endcase
      in_data = (in_valid && pix < N) ? px[pix] : 16'($urandom);
      case (rmode)
        0: out_ready = 1'b1;
        1: begin
          if (expv && stall > 0) begin
            out_ready = 1'b0;
            stall--;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      #1;
      chk(out_valid, expv, {tag, ".out_valid"});
      chk(frame_done, fin, {tag, ".frame_done"});
      chk(busy, !fin, {tag, ".busy"});
      if (fin) done = 1'b1;
      if (out_valid && oidx < NOUT) chk(out_data, exp_q[oidx], {tag, ".out_data"});
      if (pix < N) exp_rdy = completes(pix) ? (!expv || out_ready) : 1'b1;
      else         exp_rdy = 1'b0;
      chk(in_ready, exp_rdy, {tag, ".in_ready"});
      acc = in_valid && exp_rdy;
      hs  = expv && out_ready;
      fin = hs && (oidx == NOUT - 1);
      if (acc && completes(pix)) expv = 1'b1;
      else if (hs)               expv = 1'b0;
      if (hs)  oidx++;
      if (acc) pix++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk(done, 1'b1, {tag, ".frame_timeout"});
    chk(oidx, NOUT, {tag, ".out_count"});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk(in_ready, 1'b0, "reset.in_ready");
    chk(out_valid, 1'b0, "reset.out_valid");
    chk(out_data, 16'h0, "reset.out_data");
    chk(busy, 1'b0, "reset.busy");
    chk(frame_done, 1'b0, "reset.frame_done");
    rst_n = 1'b1;

    fill_ramp();
    run_frame(0, 0, -1, "ramp");

    for (int i = 0; i < N; i++) px[i] = -16'sd3;
    px[5] = -16'sd1;
    run_frame(0, 0, -1, "neg");

    fill_ramp();
    run_frame(0, 1, -1, "stall");

    // in_valid while idle must be ignored.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'($urandom);
      #1;
      chk(in_ready, 1'b0, "idle.in_ready");
      chk(busy, 1'b0, "idle.busy");
    end
    in_valid = 1'b0;
    fill_ramp();
    run_frame(0, 0, -1, "after_idle");

    // Abort a frame with reset after six pixels.
    @(negedge clk);
    start = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = 16'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk(out_valid, 1'b1, "abort.pre_valid");
    chk(out_data, post(16'sd5), "abort.pre_data");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    chk(out_valid, 1'b0, "abort.out_valid");
    chk(busy, 1'b0, "abort.busy");
    chk(in_ready, 1'b0, "abort.in_ready");
    chk(out_data, 16'h0, "abort.out_data");
    chk(frame_done, 1'b0, "abort.frame_done");
    run_frame(0, 0, -1, "post_abort");

    run_frame(1, 0, 10, "toggle");

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) px[i] = 16'($urandom);
      run_frame(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
